// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC register, redirect handling and IF/ID register
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic        halted,
    output logic [1:0]  fault
);

    typedef enum logic [1:0] {
        START  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

    state_t      state, state_n;
    logic [31:0] pc_n, instr_n, pc4_n;
    logic        valid_n;
    logic [1:0]  fault_n;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] redir_target;
    logic        redirect;

    // The jump region comes from the incremented PC, so a fetch at the end
    // of a 256 MB region jumps into the next one.
    assign pc_plus4     = pc + 32'd4;
    assign jump_target  = {pc_plus4[31:28], jump_index, 2'b00};
    assign redirect     = branch_taken | jump;
    assign redir_target = branch_taken ? branch_target : jump_target;
    assign imem_addr    = pc;
    assign halted       = (state == HALTED);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = if_instr;
        pc4_n   = if_pc4;
        valid_n = if_valid;
        fault_n = fault;
        case (state)
            START: begin
                state_n = RUN;
                valid_n = 1'b0;
            end
            RUN: begin
                if (redirect) begin
                    valid_n = 1'b0;
                    if (redir_target[1:0] != 2'b00) begin
                        state_n = HALTED;
                        fault_n = 2'b01;
                    end else if ({1'b0, redir_target} >= PC_LIMIT) begin
                        state_n = HALTED;
                        fault_n = 2'b10;
                    end else begin
                        pc_n = redir_target;
                    end
                end else if (stall) begin
                    if (flush) begin
                        valid_n = 1'b0;
                    end
                end else if ({1'b0, pc_plus4} >= PC_LIMIT) begin
                    state_n = HALTED;
                    fault_n = 2'b10;
                    valid_n = 1'b0;
                end else begin
                    instr_n = imem_instr;
                    pc4_n   = pc_plus4;
                    valid_n = ~flush;
                    pc_n    = pc_plus4;
                end
            end
            HALTED: begin
            end
            default: begin
                state_n = START;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= START;
            pc       <= RESET_PC;
            if_instr <= 32'd0;
            if_pc4   <= 32'd0;
            if_valid <= 1'b0;
            fault    <= 2'b00;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            if_instr <= instr_n;
            if_pc4   <= pc4_n;
            if_valid <= valid_n;
            fault    <= fault_n;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        halted;
    logic [1:0]  fault;

    logic [31:0] mem [0:4095];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Word i of the memory model holds 0xC000_0000 | i.
    assign imem_instr = mem[imem_addr[13:2]];

    ifetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(4096)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .pc(pc), .if_instr(if_instr), .if_pc4(if_pc4), .if_valid(if_valid),
        .halted(halted), .fault(fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic [31:0] e_pc, input logic e_valid,
                          input logic [31:0] e_instr, input logic [31:0] e_pc4);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, e_valid});
        chk({tag, ".instr"}, if_instr, e_instr);
        chk({tag, ".pc4"}, if_pc4, e_pc4);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC000_0000 | 32'(i);
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; jump = 1'b0; jump_index = 26'h0;

        step();
        chk_if("reset", 32'h0, 1'b0, 32'h0, 32'h0);
        chk("reset.halted", {31'd0, halted}, 32'd0);
        chk("reset.fault", {30'd0, fault}, 32'd0);
        chk("reset.imem_addr", imem_addr, 32'h0);

        reset = 1'b0;
        step();
        chk_if("start", 32'h0, 1'b0, 32'h0, 32'h0);

        step();
        chk_if("seq0", 32'h4, 1'b1, 32'hC000_0000, 32'h4);
        step();
        chk_if("seq1", 32'h8, 1'b1, 32'hC000_0001, 32'h8);

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_if("stall", 32'h8, 1'b1, 32'hC000_0001, 32'h8);
        end
        stall = 1'b0;
        step();
        chk_if("seq2", 32'hC, 1'b1, 32'hC000_0002, 32'hC);
        chk("seq2.imem_addr", imem_addr, 32'hC);
        step();
        step();
        chk_if("seq4", 32'h14, 1'b1, 32'hC000_0004, 32'h14);

        jump = 1'b1; jump_index = 26'd2;
        step();
        chk_if("jump", 32'h8, 1'b0, 32'hC000_0004, 32'h14);
        jump = 1'b0;
        step();
        chk_if("jump.after", 32'hC, 1'b1, 32'hC000_0002, 32'hC);

        flush = 1'b1;
        step();
        chk_if("flush", 32'h10, 1'b0, 32'hC000_0003, 32'h10);
        flush = 1'b0;
        step();
        chk_if("flush.after", 32'h14, 1'b1, 32'hC000_0004, 32'h14);

        stall = 1'b1; flush = 1'b1;
        step();
        chk_if("stallflush", 32'h14, 1'b0, 32'hC000_0004, 32'h14);
        flush = 1'b0;

        branch_taken = 1'b1; branch_target = 32'h20; jump = 1'b1; jump_index = 26'd5;
        step();
        chk_if("prio", 32'h20, 1'b0, 32'hC000_0004, 32'h14);
        branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        step();
        chk_if("prio.after", 32'h24, 1'b1, 32'hC000_0008, 32'h24);

        branch_taken = 1'b1; branch_target = 32'h6;
        step();
        chk("misal.halted", {31'd0, halted}, 32'd1);
        chk("misal.fault", {30'd0, fault}, 32'd1);
        chk_if("misal", 32'h24, 1'b0, 32'hC000_0008, 32'h24);
        branch_target = 32'h40;
        step();
        chk("sticky.halted", {31'd0, halted}, 32'd1);
        chk("sticky.fault", {30'd0, fault}, 32'd1);
        chk("sticky.pc", pc, 32'h24);

        reset = 1'b1;
        step();
        chk("rst2.halted", {31'd0, halted}, 32'd0);
        chk("rst2.fault", {30'd0, fault}, 32'd0);
        chk_if("rst2", 32'h0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0; branch_taken = 1'b0;

        step();
        chk_if("start2", 32'h0, 1'b0, 32'h0, 32'h0);
        branch_taken = 1'b1; branch_target = 32'h3FF8;
        step();
        chk_if("far", 32'h3FF8, 1'b0, 32'h0, 32'h0);
        branch_taken = 1'b0;
        step();
        chk_if("last", 32'h3FFC, 1'b1, 32'hC000_0FFE, 32'h3FFC);
        step();
        chk("oor.halted", {31'd0, halted}, 32'd1);
        chk("oor.fault", {30'd0, fault}, 32'd2);
        chk_if("oor", 32'h3FFC, 1'b0, 32'hC000_0FFE, 32'h3FFC);

        reset = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        step();
        chk("rst3.halted", {31'd0, halted}, 32'd0);
        chk("rst3.fault", {30'd0, fault}, 32'd0);
        chk_if("rst3", 32'h0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0; branch_taken = 1'b0;

        step();
        branch_taken = 1'b1; branch_target = 32'h4002;
        step();
        chk("prec.fault", {30'd0, fault}, 32'd1);
        chk("prec.pc", pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
